// File: rtl/display_pkg.sv
// display_pkg: scan states and active-low seven-segment constants shared by the digit scan driver.
package display_pkg;

   typedef enum logic [1:0] {DIG0, DIG1, DIG2, DIG3} scan_state_e;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Segment a on bit 0 through g on bit 6; a 0 lights the segment.
   localparam logic [6:0] HEX_SEG [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

endpackage

// File: rtl/hex_seg_lut.sv
// hex_seg_lut: hex nibble to active-low seven-segment pattern.
module hex_seg_lut
   import display_pkg::*;
(
   input  logic [3:0] nib_i,
   output logic [6:0] seg_o
);

   assign seg_o = HEX_SEG[nib_i];

endmodule

// File: rtl/digit_scan_driver.sv
// digit_scan_driver: four-digit multiplexed seven-segment driver with double-buffered value.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 always shown).
module digit_scan_driver
   import display_pkg::*;
#(
   parameter int REFRESH_DIV = 50000
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [15:0] value,
   input  logic        value_valid,
   input  logic        enable,
   output logic [3:0]  digit_sel,
   output logic [6:0]  seg,
   output logic        frame_done
);

   localparam int CW = $clog2(REFRESH_DIV);

   logic [CW-1:0] cnt_q, cnt_d;
   scan_state_e   state_q, state_d;
   logic [15:0]   pend_q, pend_d, disp_q, disp_d;
   logic          flag_q, flag_d;
   logic [3:0]    sel_q, sel_d, nib;
   logic [6:0]    seg_q, seg_d, hex_seg;
   logic          fd_q, tick, wrap, blank;

   hex_seg_lut u_lut (.nib_i(nib), .seg_o(hex_seg));

   always_comb begin
      tick    = (cnt_q == '0) && enable;
      wrap    = tick && (state_q == DIG3);
      cnt_d   = tick ? CW'(REFRESH_DIV - 1) : enable ? cnt_q - CW'(1) : cnt_q;
      state_d = tick ? scan_state_e'(state_q + 2'd1) : state_q;
      pend_d  = value_valid ? value : pend_q;
      flag_d  = !wrap && (value_valid || flag_q);
      // A strobe coinciding with the wrap bypasses pending so it lands in this frame.
      disp_d  = !wrap ? disp_q : value_valid ? value : flag_q ? pend_q : disp_q;
      nib     = disp_d[{state_d, 2'b00} +: 4];
`ifdef LEADING_ZERO_BLANK_EN
      blank   = (state_d == DIG3 && disp_d[15:12] == '0) ||
                (state_d == DIG2 && disp_d[15:8] == '0) ||
                (state_d == DIG1 && disp_d[15:4] == '0);
`else
      blank   = 1'b0;
`endif
      sel_d   = tick ? 4'b0001 << state_d : sel_q;
      seg_d   = tick ? (blank ? SEG_BLANK : hex_seg) : seg_q;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q   <= CW'(REFRESH_DIV - 1);
         state_q <= DIG0;
         pend_q  <= '0;
         disp_q  <= '0;
         flag_q  <= 1'b0;
         sel_q   <= 4'b0001;
         seg_q   <= HEX_SEG[0];
         fd_q    <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         state_q <= state_d;
         pend_q  <= pend_d;
         disp_q  <= disp_d;
         flag_q  <= flag_d;
         sel_q   <= sel_d;
         seg_q   <= seg_d;
         fd_q    <= wrap;
      end
   end

   assign digit_sel  = sel_q;
   assign seg        = seg_q;
   assign frame_done = fd_q;

endmodule
